conware_host: RTL and testbench

//  Host-side endpoint for the conware stream core. Streams a board out as pixels on an
//  AXI-stream master, collects the next generation on an AXI-stream slave, decodes it

---
 rtl/conware_host.sv | 196 +++++++++++++++++++
 tb/tb_conware_host.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conware_host.sv
`default_nettype none
// ============================================================================
// Module   : conware_host
// Purpose  : Host-side endpoint for the conware stream core. Streams the
//            current board out as pixels on an AXI-stream master, collects the
//            next generation on an AXI-stream slave, decodes pixels back to
//            cell bits and repeats for a programmed number of generations.
// Ports    : ACLK, ARESETN (async, active-low)
//            seed_board / num_gens / start      - run control inputs
//            busy / done / board / gen_count    - run status outputs
//            err_tlast                          - sticky inbound TLAST error
//            M_AXIS_*                           - pixel stream to conware
//            S_AXIS_*                           - pixel stream from conware
// Config   : CONWARE_HOST_TLAST_CHECK_EN - when defined, inbound TLAST is
//            compared against the beat count and mismatches set err_tlast.
//            When undefined, err_tlast stays 0 and S_AXIS_TLAST is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module conware_host #(
    parameter int                DWIDTH      = 32,
    parameter int                WIDTH       = 4,
    parameter int                HEIGHT      = 4,
    parameter int                GEN_W       = 16,
    parameter logic [DWIDTH-1:0] ALIVE_COLOR = 32'h00FFFFFF,
    parameter logic [DWIDTH-1:0] DEAD_COLOR  = 32'h00000000
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [WIDTH*HEIGHT-1:0]   seed_board,
    input  logic [GEN_W-1:0]          num_gens,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH*HEIGHT-1:0]   board,
    output logic [GEN_W-1:0]          gen_count,
    output logic                      err_tlast,
    output logic                      M_AXIS_TVALID,
    input  logic                      M_AXIS_TREADY,
    output logic [DWIDTH-1:0]         M_AXIS_TDATA,
    output logic                      M_AXIS_TLAST,
    input  logic                      S_AXIS_TVALID,
    output logic                      S_AXIS_TREADY,
    input  logic [DWIDTH-1:0]         S_AXIS_TDATA,
    input  logic                      S_AXIS_TLAST
);

    localparam int c_N     = WIDTH * HEIGHT;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_N - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SEND = 2'd1;
    localparam logic [1:0] c_ST_RECV = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_N-1:0]     r_shadow;
    logic [c_N-1:0]     r_board;
    logic [GEN_W-1:0]   r_gen_count;
    logic [GEN_W-1:0]   r_num_gens;
    logic               r_busy;
    logic               r_done;
    logic               r_err_tlast;
    logic               r_m_tvalid;
    logic [DWIDTH-1:0]  r_m_tdata;
    logic               r_m_tlast;
    logic               r_s_tready;

    logic [c_IDX_W-1:0] w_idx_nxt;
    logic               w_is_last;
    logic               w_pix_alive;
    logic [c_N-1:0]     w_shadow_nxt;
    logic [GEN_W-1:0]   w_gen_inc;

    assign w_idx_nxt   = r_idx + c_IDX_W'(1);
    assign w_is_last   = (r_idx == c_LAST);
    assign w_pix_alive = (S_AXIS_TDATA == ALIVE_COLOR);
    assign w_gen_inc   = r_gen_count + GEN_W'(1);

    // Shadow board including the beat currently being accepted, so the last
    // beat can be folded into the published board in the same cycle.
    always_comb begin
        w_shadow_nxt        = r_shadow;
        w_shadow_nxt[r_idx] = w_pix_alive;
    end

`ifndef CONWARE_HOST_TLAST_CHECK_EN
    // Inbound TLAST has no function when the check is compiled out.
    logic w_unused_tlast;
    assign w_unused_tlast = S_AXIS_TLAST;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= c_ST_IDLE;
            r_idx       <= '0;
            r_shadow    <= '0;
            r_board     <= '0;
            r_gen_count <= '0;
            r_num_gens  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_tlast <= 1'b0;
            r_m_tvalid  <= 1'b0;
            r_m_tdata   <= '0;
            r_m_tlast   <= 1'b0;
            r_s_tready  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_board     <= seed_board;
                        r_err_tlast <= 1'b0;
                        if (num_gens != '0) begin
                            r_num_gens  <= num_gens;
                            r_gen_count <= '0;
                            r_idx       <= '0;
                            r_busy      <= 1'b1;
                            r_state     <= c_ST_SEND;
                        end else begin
                            // Zero-generation run: publish the seed and finish.
                            r_done <= 1'b1;
                        end
                    end
                end

                c_ST_SEND: begin
                    if (!r_m_tvalid) begin
                        // First cycle in SEND: present beat 0.
                        r_m_tvalid <= 1'b1;
                        r_m_tdata  <= r_board[r_idx] ? ALIVE_COLOR : DEAD_COLOR;
                        r_m_tlast  <= w_is_last;
                    end else if (M_AXIS_TREADY) begin
                        if (w_is_last) begin
                            r_m_tvalid <= 1'b0;
                            r_m_tlast  <= 1'b0;
                            r_idx      <= '0;
                            r_state    <= c_ST_RECV;
                        end else begin
                            r_idx     <= w_idx_nxt;
                            r_m_tdata <= r_board[w_idx_nxt] ? ALIVE_COLOR : DEAD_COLOR;
                            r_m_tlast <= (w_idx_nxt == c_LAST);
                        end
                    end
                end

                c_ST_RECV: begin
                    if (!r_s_tready) begin
                        r_s_tready <= 1'b1;
                    end else if (S_AXIS_TVALID) begin
                        r_shadow <= w_shadow_nxt;
`ifdef CONWARE_HOST_TLAST_CHECK_EN
                        if (S_AXIS_TLAST != w_is_last) begin
                            r_err_tlast <= 1'b1;
                        end
`endif
                        // The beat count, not inbound TLAST, closes a frame.
                        if (w_is_last) begin
                            r_board     <= w_shadow_nxt;
                            r_gen_count <= w_gen_inc;
                            r_s_tready  <= 1'b0;
                            r_idx       <= '0;
                            r_state     <= (w_gen_inc == r_num_gens) ? c_ST_DONE : c_ST_SEND;
                        end else begin
                            r_idx <= w_idx_nxt;
                        end
                    end
                end

                c_ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign board         = r_board;
    assign gen_count     = r_gen_count;
    assign err_tlast     = r_err_tlast;
    assign M_AXIS_TVALID = r_m_tvalid;
    assign M_AXIS_TDATA  = r_m_tdata;
    assign M_AXIS_TLAST  = r_m_tlast;
    assign S_AXIS_TREADY = r_s_tready;

endmodule
`default_nettype wire

// File: tb/tb_conware_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_conware_host
// Purpose  : Directed self-checking bench for conware_host (4x4 board). A
//            behavioural stand-in for the conware core sits on both streams
//            and either echoes the board or computes a Life step with dead
//            borders; expected boards are hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conware_host;

    localparam logic [31:0] c_ALIVE = 32'h00FFFFFF;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [15:0] seed_board;
    logic [15:0] num_gens;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] board;
    logic [15:0] gen_count;
    logic        err_tlast;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TLAST;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TREADY;
    logic [31:0] S_AXIS_TDATA;
    logic        S_AXIS_TLAST;

    int n_vec = 0;
    int n_err = 0;

    // Per-run observations
    int m_beats, s_beats, tdata_err, tlast_err, stall_err, vcyc, first_tv;
    int brd_err, rv_err, done_cnt, done_at;
    logic err_after_start;

    conware_host #(
        .DWIDTH     (32),
        .WIDTH      (4),
        .HEIGHT     (4),
        .GEN_W      (16),
        .ALIVE_COLOR(32'h00FFFFFF),
        .DEAD_COLOR (32'h00000000)
    ) u_dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .seed_board   (seed_board),
        .num_gens     (num_gens),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .board        (board),
        .gen_count    (gen_count),
        .err_tlast    (err_tlast),
        .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TDATA (M_AXIS_TDATA),
        .M_AXIS_TLAST (M_AXIS_TLAST),
        .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TREADY(S_AXIS_TREADY),
        .S_AXIS_TDATA (S_AXIS_TDATA),
        .S_AXIS_TLAST (S_AXIS_TLAST)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One Life generation on a 4x4 board with dead cells beyond the edge.
    function automatic logic [15:0] life(input logic [15:0] b);
        logic [15:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 4 &&
                            (c + dc) >= 0 && (c + dc) < 4 && b[(r + dr) * 4 + c + dc])
                            cnt++;
                    end
                end
                n[r * 4 + c] = b[r * 4 + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return n;
    endfunction

    // Accept nb beats from the master stream; toggle=1 alternates TREADY 0/1.
    task automatic collect_m(input int nb, input logic [15:0] exp_b, input int toggle);
        int cyc;
        int got;
        logic hold;
        logic [31:0] hd;
        logic hl;
        cyc = 0; got = 0; hold = 1'b0; hd = '0; hl = 1'b0;
        while (got < nb) begin
            @(negedge ACLK);
            cyc++;
            if (cyc > 200) begin
                chk("m_timeout", 32'd1, 32'd0);
                return;
            end
            M_AXIS_TREADY = (toggle != 0) ? ((cyc % 2) == 0) : 1'b1;
            if (hold && (M_AXIS_TDATA !== hd || M_AXIS_TLAST !== hl)) stall_err++;
            if (M_AXIS_TVALID === 1'b1) begin
                if (first_tv < 0) first_tv = cyc;
                vcyc++;
                if (M_AXIS_TREADY) begin
                    if (M_AXIS_TDATA !== (exp_b[got] ? c_ALIVE : 32'h0)) tdata_err++;
                    if (M_AXIS_TLAST !== (got == 15)) tlast_err++;
                    got++;
                    m_beats++;
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    hd   = M_AXIS_TDATA;
                    hl   = M_AXIS_TLAST;
                end
            end else begin
                hold = 1'b0;
            end
        end
    endtask

    // Return a 16-pixel frame. mode 2: cell 0 uses an off-by-one live colour;
    // mode 3: TLAST also raised on beat 7.
    task automatic drive_s(input logic [15:0] resp, input int mode, input logic [15:0] prev);
        int k;
        int cyc;
        k = 0; cyc = 0;
        while (k < 16) begin
            @(negedge ACLK);
            cyc++;
            if (cyc > 200) begin
                chk("s_timeout", 32'd1, 32'd0);
                S_AXIS_TVALID = 1'b0;
                return;
            end
            if (M_AXIS_TVALID !== 1'b0) rv_err++;
            if (board !== prev) brd_err++;
            S_AXIS_TVALID = 1'b1;
            S_AXIS_TDATA  = resp[k] ? ((mode == 2 && k == 0) ? 32'h00FFFFFE : c_ALIVE) : 32'h0;
            S_AXIS_TLAST  = (k == 15) || (mode == 3 && k == 7);
            if (S_AXIS_TREADY === 1'b1) begin
                k++;
                s_beats++;
            end
        end
        @(negedge ACLK);
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        S_AXIS_TDATA  = '0;
    endtask

    task automatic wait_done();
        done_cnt = 0; done_at = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge ACLK);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
        end
    endtask

    task automatic do_start(input logic [15:0] seed, input logic [15:0] ng);
        @(negedge ACLK);
        seed_board = seed;
        num_gens   = ng;
        start      = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        err_after_start = err_tlast;
    endtask

    task automatic run(input logic [15:0] seed, input logic [15:0] ng, input int mode, input int toggle);
        logic [15:0] cur;
        logic [15:0] resp;
        m_beats = 0; s_beats = 0; tdata_err = 0; tlast_err = 0; stall_err = 0;
        vcyc = 0; first_tv = -1; brd_err = 0; rv_err = 0;
        do_start(seed, ng);
        cur = seed;
        for (int g = 0; g < int'(ng); g++) begin
            collect_m(16, cur, toggle);
            resp = (mode == 0) ? life(cur) : cur;
            drive_s(resp, mode, cur);
            cur = (mode == 2) ? (resp & 16'hFFFE) : resp;
        end
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int tv_seen;
        ARESETN = 1'b0; seed_board = '0; num_gens = '0; start = 1'b0;
        M_AXIS_TREADY = 1'b1; S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0; S_AXIS_TLAST = 1'b0;
        repeat (3) @(negedge ACLK);

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_board", 32'(board), 32'd0);
        chk("rst_gen", 32'(gen_count), 32'd0);
        chk("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        chk("rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
        chk("rst_tdata", M_AXIS_TDATA, 32'd0);
        chk("rst_sready", 32'(S_AXIS_TREADY), 32'd0);
        chk("rst_err", 32'(err_tlast), 32'd0);
        @(negedge ACLK); ARESETN = 1'b1;
        @(negedge ACLK);

        // Stable block through three Life generations
        run(16'h0033, 16'd3, 0, 0);
        chk("t1_m_beats", m_beats, 48);
        chk("t1_s_beats", s_beats, 48);
        chk("t1_board", 32'(board), 32'h0033);
        chk("t1_gen", 32'(gen_count), 32'd3);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_lat", done_at, 1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_tv_lat", first_tv, 1);
        chk("t1_tdata", tdata_err, 0);
        chk("t1_tlast", tlast_err, 0);
        chk("t1_board_hold", brd_err, 0);
        chk("t1_tv_in_recv", rv_err, 0);

        // Blinker: vertical bar at column 1 becomes horizontal bar on row 1
        run(16'h0222, 16'd1, 0, 0);
        chk("blink_board", 32'(board), 32'h0070);
        chk("blink_gen", 32'(gen_count), 32'd1);

        // Echo with TREADY toggling
        run(16'hA5C3, 16'd1, 1, 1);
        chk("t2_board", 32'(board), 32'hA5C3);
        chk("t2_vcyc", vcyc, 32);
        chk("t2_stall", stall_err, 0);
        chk("t2_tdata", tdata_err, 0);
        chk("t2_tlast", tlast_err, 0);
        chk("t2_m_beats", m_beats, 16);

        // Zero generations
        @(negedge ACLK);
        seed_board = 16'h1234; num_gens = 16'd0; start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_board", 32'(board), 32'h1234);
        chk("t3_busy", 32'(busy), 32'd0);
        tv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (M_AXIS_TVALID !== 1'b0) tv_seen++;
            @(negedge ACLK);
            if (i == 0) chk("t3_done_pulse", 32'(done), 32'd0);
        end
        chk("t3_no_tvalid", tv_seen, 0);

        // Asynchronous reset mid-send, then a clean run
        m_beats = 0; tdata_err = 0; tlast_err = 0; stall_err = 0; vcyc = 0; first_tv = -1;
        do_start(16'hFFFF, 16'd2);
        collect_m(5, 16'hFFFF, 0);
        @(negedge ACLK);
        ARESETN = 1'b0;
        #1;
        chk("t4_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_board", 32'(board), 32'd0);
        @(negedge ACLK); ARESETN = 1'b1;
        run(16'h0033, 16'd1, 1, 0);
        chk("t4_board_after", 32'(board), 32'h0033);
        chk("t4_done_cnt", done_cnt, 1);

        // Near-miss live colour decodes as dead
        run(16'h0033, 16'd1, 2, 0);
        chk("t5_board", 32'(board), 32'h0032);

        // Spurious inbound TLAST on beat 7
        run(16'h0033, 16'd1, 3, 0);
        chk("t6_board", 32'(board), 32'h0033);
`ifdef CONWARE_HOST_TLAST_CHECK_EN
        chk("t6_err", 32'(err_tlast), 32'd1);
`else
        chk("t6_err", 32'(err_tlast), 32'd0);
`endif
        run(16'h0001, 16'd1, 1, 0);
        chk("t6_err_clr", 32'(err_after_start), 32'd0);
        chk("t6_err_end", 32'(err_tlast), 32'd0);
        chk("t6_board2", 32'(board), 32'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
